// File: rtl/zld_xcb_pkg.sv
// Shared definitions for the zero run-length decoder: widths, token
// field positions and FSM state encoding.
package zld_xcb_pkg;

    // Decoded value width; a token is one bit wider.
    localparam int W = 7;

    // Token layout: bit W selects run (1) or literal (0);
    // bits W-1:0 carry the literal value or the zero-run count.
    localparam int TOK_RUN = W;

    typedef enum logic {
        S_PASS = 1'b0,  // accepting tokens
        S_ZERO = 1'b1   // emitting the remainder of a zero run
    } state_t;

endpackage

// File: rtl/zld_xcb_if.sv
// Token-in / value-out stream bundle for the zero run-length decoder.
//
// Handshake (d, v, b triple): a transfer happens on a rising clock edge
// when v=1 and b=0 in the same cycle. b is back-pressure (1 = cannot
// accept). The producer holds d stable while v=1 and b=1.
interface zld_xcb_if import zld_xcb_pkg::*; ();

    logic [W:0]   i_d;        // token in
    logic         i_v;        // token valid
    logic         i_b;        // back-pressure to upstream
    logic [W-1:0] o_d;        // decoded value
    logic         o_v;        // decoded value valid
    logic         o_b;        // back-pressure from downstream
    state_t       dbg_state;  // FSM state, for observation only

    modport slave (
        input  i_d, i_v, o_b,
        output i_b, o_d, o_v, dbg_state
    );

    modport master (
        output i_d, i_v, o_b,
        input  i_b, o_d, o_v, dbg_state
    );

endinterface

// File: rtl/zld_xcb_dp.sv
// Datapath: output holding register, remaining-zeros counter and the
// decode flags consumed by the FSM.
module zld_xcb_dp import zld_xcb_pkg::*; (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W:0]   i_d,
    input  logic         i_ld_lit,
    input  logic         i_ld_zero,
    input  logic         i_ld_rem,
    input  logic         i_dec_rem,
    input  logic         i_clr_v,
    output logic [W-1:0] o_d,
    output logic         o_v,
    output logic         o_f_tok_run,
    output logic         o_f_cnt_eq_0,
    output logic         o_f_cnt_eq_1,
    output logic         o_f_rem_eq_1
);

    logic [W-1:0] r_d;
    logic         r_v;
    logic [W-1:0] r_rem;
    logic [W-1:0] w_field;

    assign w_field      = i_d[W-1:0];
    assign o_f_tok_run  = i_d[TOK_RUN];
    assign o_f_cnt_eq_0 = (w_field == '0);
    assign o_f_cnt_eq_1 = (w_field == W'(1));
    assign o_f_rem_eq_1 = (r_rem == W'(1));
    assign o_d          = r_d;
    assign o_v          = r_v;

    // Output holding register: literal, zero, or drain to empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_d <= '0;
            r_v <= 1'b0;
        end else if (i_ld_lit) begin
            r_d <= w_field;
            r_v <= 1'b1;
        end else if (i_ld_zero) begin
            r_d <= '0;
            r_v <= 1'b1;
        end else if (i_clr_v) begin
            r_v <= 1'b0;
        end
    end

    // Zeros still to load after the one currently being loaded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem <= '0;
        end else if (i_ld_rem) begin
            r_rem <= w_field - W'(1);
        end else if (i_dec_rem) begin
            r_rem <= r_rem - W'(1);
        end
    end

endmodule

// File: rtl/zld_xcb_fsm.sv
// Control FSM: owns the state, the upstream back-pressure and the
// datapath load/decrement enables.
module zld_xcb_fsm import zld_xcb_pkg::*; (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_v,           // token valid
    input  logic   i_out_v,       // holding register full
    input  logic   i_out_b,       // downstream back-pressure
    input  logic   i_f_tok_run,   // token is a zero run
    input  logic   i_f_cnt_eq_0,  // token field == 0
    input  logic   i_f_cnt_eq_1,  // token field == 1
    input  logic   i_f_rem_eq_1,  // last zero of the run is next
    output logic   o_in_b,        // back-pressure to upstream
    output logic   o_ld_lit,      // load literal into holding register
    output logic   o_ld_zero,     // load a zero into holding register
    output logic   o_ld_rem,      // load rem with count-1
    output logic   o_dec_rem,     // decrement rem
    output logic   o_clr_v,       // holding register drained, nothing new
    output state_t o_state
);

    state_t r_state;
    state_t w_next;
    logic   w_can_load;

    // Holding register is empty or is being consumed this cycle.
    assign w_can_load = ~i_out_v | ~i_out_b;
    assign o_state    = r_state;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_PASS;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and datapath enables; i_b never looks at i_v.
    always_comb begin
        w_next    = r_state;
        o_in_b    = 1'b1;
        o_ld_lit  = 1'b0;
        o_ld_zero = 1'b0;
        o_ld_rem  = 1'b0;
        o_dec_rem = 1'b0;
        o_clr_v   = 1'b0;
        case (r_state)
            S_PASS: begin
                o_in_b = ~w_can_load;
                if (w_can_load) begin
                    if (i_v) begin
                        if (!i_f_tok_run) begin
                            o_ld_lit = 1'b1;
                        end else if (i_f_cnt_eq_0) begin
                            // Reserved count: swallow the token silently.
                            o_clr_v = 1'b1;
                        end else if (i_f_cnt_eq_1) begin
                            o_ld_zero = 1'b1;
                        end else begin
                            o_ld_zero = 1'b1;
                            o_ld_rem  = 1'b1;
                            w_next    = S_ZERO;
                        end
                    end else begin
                        o_clr_v = 1'b1;
                    end
                end
            end
            S_ZERO: begin
                if (w_can_load) begin
                    o_ld_zero = 1'b1;
                    o_dec_rem = 1'b1;
                    if (i_f_rem_eq_1) begin
                        w_next = S_PASS;
                    end
                end
            end
            default: begin
                w_next = S_PASS;
            end
        endcase
    end

endmodule

// File: rtl/zld_xcb.sv
// Zero run-length decoder top: expands literal and zero-run tokens into
// a registered stream of W-bit values.
module zld_xcb import zld_xcb_pkg::*; (
    input  logic clock,
    input  logic reset,   // asynchronous, active low
    zld_xcb_if.slave bus
);

    logic w_ld_lit;
    logic w_ld_zero;
    logic w_ld_rem;
    logic w_dec_rem;
    logic w_clr_v;
    logic w_f_tok_run;
    logic w_f_cnt_eq_0;
    logic w_f_cnt_eq_1;
    logic w_f_rem_eq_1;
    logic w_o_v;

    assign bus.o_v = w_o_v;

    zld_xcb_fsm u_fsm (
        .i_clk        (clock),
        .i_rst_n      (reset),
        .i_v          (bus.i_v),
        .i_out_v      (w_o_v),
        .i_out_b      (bus.o_b),
        .i_f_tok_run  (w_f_tok_run),
        .i_f_cnt_eq_0 (w_f_cnt_eq_0),
        .i_f_cnt_eq_1 (w_f_cnt_eq_1),
        .i_f_rem_eq_1 (w_f_rem_eq_1),
        .o_in_b       (bus.i_b),
        .o_ld_lit     (w_ld_lit),
        .o_ld_zero    (w_ld_zero),
        .o_ld_rem     (w_ld_rem),
        .o_dec_rem    (w_dec_rem),
        .o_clr_v      (w_clr_v),
        .o_state      (bus.dbg_state)
    );

    zld_xcb_dp u_dp (
        .i_clk        (clock),
        .i_rst_n      (reset),
        .i_d          (bus.i_d),
        .i_ld_lit     (w_ld_lit),
        .i_ld_zero    (w_ld_zero),
        .i_ld_rem     (w_ld_rem),
        .i_dec_rem    (w_dec_rem),
        .i_clr_v      (w_clr_v),
        .o_d          (bus.o_d),
        .o_v          (w_o_v),
        .o_f_tok_run  (w_f_tok_run),
        .o_f_cnt_eq_0 (w_f_cnt_eq_0),
        .o_f_cnt_eq_1 (w_f_cnt_eq_1),
        .o_f_rem_eq_1 (w_f_rem_eq_1)
    );

endmodule

// File: tb/tb_zld_xcb.sv
// Self-checking bench for the zero run-length decoder: directed cases
// with cycle-exact timing, then a randomized token stream scored
// against a queue of expanded values.
module tb_zld_xcb;
  import zld_xcb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  zld_xcb_if bus ();

  zld_xcb u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic         hold_pending = 1'b0;
  logic [W-1:0] hold_d = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what a token expands to, straight from the token rules.
  task automatic expand(input logic [W:0] tok);
    if (tok[W] == 1'b0) begin
      exp_q.push_back(tok[W-1:0]);
    end else begin
      for (int k = 0; k < int'(tok[W-1:0]); k++) exp_q.push_back('0);
    end
  endtask

  // ---------------- driver / monitor ----------------
  // One cycle: drive at negedge, observe 1ns later (before the next
  // rising edge), score an output transfer and record an input accept.
  task automatic step(input logic v, input logic [W:0] d, input logic b,
                      output logic acc, output logic xv, output logic [W-1:0] xd);
    @(negedge clock);
    bus.i_v = v;
    bus.i_d = d;
    bus.o_b = b;
    #1;
    if (hold_pending) begin
      check("hold_v", bus.o_v, 1);
      check("hold_d", bus.o_d, hold_d);
    end
    hold_pending = bus.o_v & bus.o_b;
    hold_d       = bus.o_d;
    xv = bus.o_v & ~bus.o_b;
    xd = bus.o_d;
    if (xv) begin
      check("q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("out_d", bus.o_d, exp_q.pop_front());
    end
    acc = v & ~bus.i_b;
    if (acc) expand(d);
  endtask

  // ---------------- stimulus ----------------
  logic         acc, xv;
  logic [W-1:0] xd;
  int           zeros, acc_idx, lit_idx;
  logic         sent;
  logic         ob_seq[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [W:0]   toks[300];
  int           idx, guard;

  initial begin
    reset   = 1'b0;
    bus.i_v = 1'b0;
    bus.i_d = '0;
    bus.o_b = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_o_v", bus.o_v, 0);
    check("rst_o_d", bus.o_d, 0);
    check("rst_i_b", bus.i_b, 0);
    check("rst_state", bus.dbg_state, S_PASS);
    @(negedge clock);
    reset = 1'b1;

    // Literals back-to-back, including a literal zero.
    step(1, 8'h05, 0, acc, xv, xd); check("t1_acc0", acc, 1);
    step(1, 8'h7F, 0, acc, xv, xd); check("t1_acc1", acc, 1); check("t1_v0", xv, 1); check("t1_d0", xd, 7'h05);
    step(1, 8'h00, 0, acc, xv, xd); check("t1_acc2", acc, 1); check("t1_v1", xv, 1); check("t1_d1", xd, 7'h7F);
    step(0, 8'h00, 0, acc, xv, xd); check("t1_v2", xv, 1); check("t1_d2", xd, 7'h00);
    step(0, 8'h00, 0, acc, xv, xd); check("t1_idle", xv, 0);

    // Run of 3 then a literal: i_b high for exactly two cycles.
    step(1, 8'h83, 0, acc, xv, xd); check("t2_acc_run", acc, 1);
    step(1, 8'h11, 0, acc, xv, xd); check("t2_blk0", acc, 0); check("t2_z0", {xv, xd}, {1'b1, 7'h00});
    step(1, 8'h11, 0, acc, xv, xd); check("t2_blk1", acc, 0); check("t2_z1", {xv, xd}, {1'b1, 7'h00});
    step(1, 8'h11, 0, acc, xv, xd); check("t2_acc_lit", acc, 1); check("t2_z2", {xv, xd}, {1'b1, 7'h00});
    step(0, 8'h00, 0, acc, xv, xd); check("t2_lit", {xv, xd}, {1'b1, 7'h11});
    step(0, 8'h00, 0, acc, xv, xd); check("t2_idle", xv, 0);

    // Maximum run: 127 zeros, literal follows without a bubble.
    step(1, 8'hFF, 0, acc, xv, xd); check("t3_acc_run", acc, 1);
    zeros = 0; acc_idx = 0; lit_idx = 0; sent = 1'b0;
    for (int i = 1; i <= 130; i++) begin
      step(!sent, 8'h2A, 0, acc, xv, xd);
      if (acc) begin sent = 1'b1; acc_idx = i; end
      if (xv && xd == 7'h00 && lit_idx == 0) zeros++;
      if (xv && xd == 7'h2A) lit_idx = i;
    end
    check("t3_zeros", zeros, 127);
    check("t3_acc_idx", acc_idx, 127);
    check("t3_lit_idx", lit_idx, 128);

    // Reserved zero-length run between two literals.
    step(1, 8'h01, 0, acc, xv, xd); check("t4_acc0", acc, 1);
    step(1, 8'h80, 0, acc, xv, xd); check("t4_acc1", acc, 1); check("t4_o1", {xv, xd}, {1'b1, 7'h01});
    step(1, 8'h02, 0, acc, xv, xd); check("t4_acc2", acc, 1); check("t4_gap", xv, 0);
    step(0, 8'h00, 0, acc, xv, xd); check("t4_o2", {xv, xd}, {1'b1, 7'h02});
    step(0, 8'h00, 0, acc, xv, xd); check("t4_idle", xv, 0);

    // Run of 5 under a back-pressure pattern.
    step(1, 8'h85, 0, acc, xv, xd); check("t5_acc_run", acc, 1);
    zeros = 0; acc_idx = 0;
    for (int i = 0; i < 8; i++) begin
      step(acc_idx == 0, 8'h33, ob_seq[i], acc, xv, xd);
      if (acc) acc_idx = i + 1;
      if (xv && xd == 7'h00) zeros++;
    end
    check("t5_zeros", zeros, 5);
    check("t5_acc_idx", acc_idx, 8);
    step(0, 8'h00, 0, acc, xv, xd); check("t5_lit", {xv, xd}, {1'b1, 7'h33});

    // Asynchronous reset in the middle of a run.
    step(1, 8'h90, 0, acc, xv, xd); check("t6_acc_run", acc, 1);
    repeat (3) step(0, 8'h00, 0, acc, xv, xd);
    @(posedge clock);
    #3;
    bus.o_b = 1'b1;
    reset   = 1'b0;
    #1;
    check("t6_rst_o_v", bus.o_v, 0);
    check("t6_rst_i_b", bus.i_b, 0);
    check("t6_rst_state", bus.dbg_state, S_PASS);
    exp_q.delete();
    hold_pending = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step(1, 8'h22, 0, acc, xv, xd); check("t6_acc", acc, 1);
    step(0, 8'h00, 0, acc, xv, xd); check("t6_lit", {xv, xd}, {1'b1, 7'h22});
    step(0, 8'h00, 0, acc, xv, xd); check("t6_idle", xv, 0);

    // Randomized token stream with random valid and back-pressure.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: toks[i] = {1'b0, 7'($urandom_range(0, 127))};
        5, 6, 7:       toks[i] = {1'b1, 7'($urandom_range(0, 6))};
        8:             toks[i] = {1'b1, 7'($urandom_range(0, 1))};
        default:       toks[i] = {1'b1, 7'($urandom_range(0, 127))};
      endcase
    end
    idx = 0; guard = 0;
    while (idx < 300 && guard < 40000) begin
      step($urandom_range(0, 3) != 0, toks[idx], $urandom_range(0, 2) == 0, acc, xv, xd);
      if (acc) idx++;
      guard++;
    end
    check("rnd_all_sent", idx, 300);
    guard = 0;
    while ((exp_q.size() != 0 || hold_pending) && guard < 4000) begin
      step(0, 8'h00, $urandom_range(0, 3) == 0, acc, xv, xd);
      guard++;
    end
    check("rnd_drained", exp_q.size(), 0);
    step(0, 8'h00, 0, acc, xv, xd);
    check("rnd_idle", xv, 0);
    check("rnd_i_b", bus.i_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
